// File: rtl/mem_store_ctrl.sv
// mem_store_ctrl: issues one store onto the data-memory bus using a req/ack handshake.
//   Parameters: TIMEOUT is the maximum number of REQ cycles allowed without an ack.
//               CNT_W is the width of the wait counter.
//   Inputs : i_clock, i_reset (async active-low), i_start, i_ir[31:0], i_addr[31:0],
//            i_wdata[31:0], i_mem_ack
//   Outputs: o_busy, o_done, o_err, o_misalign, o_mem_req, o_mem_addr[31:0],
//            o_mem_wrbits[3:0], o_mem_wdata[31:0]
//   Optional: define MEM_STORE_MISALIGN_TRAP_EN to trap misaligned SH/SW instead of issuing them.
module mem_store_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_ir,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_mem_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_misalign,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_wrbits,
    output logic [31:0] o_mem_wdata
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_FIN = 2'd2} state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr, r_wdata;
    logic [3:0]       r_wrbits;
    logic             r_err;
    logic [2:0]       w_size;
    logic             w_valid, w_issue, w_timeout, w_launch;
    logic [3:0]       w_wrbits;
    logic             w_unused;

    assign w_size    = i_ir[14:12];
    assign w_valid   = (i_ir[6:0] == 7'b0100011) && (w_size < 3'd3);
    assign w_wrbits  = (w_size == 3'd0) ? (4'b0001 << i_addr[1:0]) :
                       (w_size == 3'd1) ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_timeout = r_cnt == CNT_W'(TIMEOUT - 1);
    assign w_unused  = &{1'b0, i_ir[31:15], i_ir[11:7]};

`ifdef MEM_STORE_MISALIGN_TRAP_EN
    logic w_misal;
    logic r_misalign;
    assign w_misal = ((w_size == 3'd1) && i_addr[0]) || ((w_size == 3'd2) && (i_addr[1:0] != 2'b00));
    assign w_issue = w_valid && !w_misal;
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_misalign <= 1'b0;
        else          r_misalign <= (r_state == S_IDLE) && i_start && w_valid && w_misal;
    end
    assign o_misalign = r_misalign;
`else
    assign w_issue    = w_valid;
    assign o_misalign = 1'b0;
`endif

    assign w_launch = (r_state == S_IDLE) && i_start && w_issue;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_start ? (w_issue ? S_REQ : S_FIN) : S_IDLE;
            S_REQ:   w_next = (i_mem_ack || w_timeout) ? S_FIN : S_REQ;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wrbits <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            // ack has priority over a coincident timeout
            r_err   <= (r_state == S_REQ) && !i_mem_ack && w_timeout;
            if (w_launch) begin
                r_addr   <= {i_addr[31:2], 2'b00};
                r_wdata  <= i_wdata;
                r_wrbits <= w_wrbits;
                r_cnt    <= '0;
            end else if ((r_state == S_REQ) && !i_mem_ack && !w_timeout) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_busy       = r_state == S_REQ;
    assign o_mem_req    = r_state == S_REQ;
    assign o_done       = r_state == S_FIN;
    assign o_err        = r_err;
    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_wdata;
    // byte enables are only presented while the request is live
    assign o_mem_wrbits = (r_state == S_REQ) ? r_wrbits : 4'b0000;
endmodule

// File: tb/tb_mem_store_ctrl.sv
// tb_mem_store_ctrl: directed table-driven bench for mem_store_ctrl plus timeout/reset sequences.
module tb_mem_store_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start_b = 1'b0, ack = 1'b0;
    logic [31:0] ir = 32'h0, addr = 32'h0, wdata = 32'h0;
    logic        busy, done, err, mis, req;
    logic [31:0] maddr, mwdata;
    logic [3:0]  wrb;
    logic        b_busy, b_done, b_err, b_mis, b_req;
    logic [31:0] b_maddr, b_mwdata;
    logic [3:0]  b_wrb;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem_store_ctrl #(.TIMEOUT(8), .CNT_W(8)) u_dut (
        .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_ir(ir), .i_addr(addr),
        .i_wdata(wdata), .i_mem_ack(ack), .o_busy(busy), .o_done(done), .o_err(err),
        .o_misalign(mis), .o_mem_req(req), .o_mem_addr(maddr), .o_mem_wrbits(wrb),
        .o_mem_wdata(mwdata));

    mem_store_ctrl #(.TIMEOUT(4), .CNT_W(8)) u_to (
        .i_clock(clk), .i_reset(rst_n), .i_start(start_b), .i_ir(ir), .i_addr(addr),
        .i_wdata(wdata), .i_mem_ack(ack), .o_busy(b_busy), .o_done(b_done), .o_err(b_err),
        .o_misalign(b_mis), .o_mem_req(b_req), .o_mem_addr(b_maddr), .o_mem_wrbits(b_wrb),
        .o_mem_wdata(b_mwdata));

    typedef struct {
        logic [31:0] ir;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [3:0]  wrb;
        logic [31:0] maddr;
        logic        issue;
        logic        mis;
    } vec_t;

    vec_t tv[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        ir = v.ir; addr = v.addr; wdata = v.wdata; start = 1'b1;
        step();
        start = 1'b0;
        ir = 32'h0000_0013; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        if (v.issue) begin
            for (int k = 0; k <= v.dly; k++) begin
                chk1($sformatf("v%0d req c%0d", idx, k), req, 1'b1);
                chk1($sformatf("v%0d busy c%0d", idx, k), busy, 1'b1);
                chk1($sformatf("v%0d done c%0d", idx, k), done, 1'b0);
                chk32($sformatf("v%0d addr c%0d", idx, k), maddr, v.maddr);
                chk32($sformatf("v%0d wdata c%0d", idx, k), mwdata, v.wdata);
                chk32($sformatf("v%0d wrbits c%0d", idx, k), 32'(wrb), 32'(v.wrb));
                ack = (k == v.dly);
                step();
            end
            ack = 1'b0;
        end
        chk1($sformatf("v%0d done", idx), done, 1'b1);
        chk1($sformatf("v%0d err", idx), err, 1'b0);
        chk1($sformatf("v%0d misalign", idx), mis, v.mis);
        chk1($sformatf("v%0d req fin", idx), req, 1'b0);
        chk32($sformatf("v%0d wrbits fin", idx), 32'(wrb), 32'h0);
        step();
        chk1($sformatf("v%0d done drop", idx), done, 1'b0);
        chk1($sformatf("v%0d misalign drop", idx), mis, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0] = '{32'h0000_0023, 32'h0000_1003, 32'hAAAA_AAAA, 0, 4'b1000, 32'h0000_1000, 1'b1, 1'b0};
        tv[1] = '{32'h0000_1023, 32'h0000_2002, 32'h1234_1234, 5, 4'b1100, 32'h0000_2000, 1'b1, 1'b0};
        tv[2] = '{32'h0000_2023, 32'h0000_0010, 32'hDEAD_BEEF, 2, 4'b1111, 32'h0000_0010, 1'b1, 1'b0};
        tv[3] = '{32'h0000_0013, 32'h0000_0100, 32'h1111_1111, 0, 4'b0000, 32'h0, 1'b0, 1'b0};
        tv[4] = '{32'h0000_3023, 32'h0000_0200, 32'h2222_2222, 0, 4'b0000, 32'h0, 1'b0, 1'b0};
        tv[5] = '{32'h0000_0023, 32'h0000_0301, 32'h5555_5555, 1, 4'b0010, 32'h0000_0300, 1'b1, 1'b0};
        tv[6] = '{32'h0000_0023, 32'h0000_0402, 32'h6666_6666, 0, 4'b0100, 32'h0000_0400, 1'b1, 1'b0};
        tv[7] = '{32'h0000_1023, 32'h0000_0500, 32'h7777_7777, 3, 4'b0011, 32'h0000_0500, 1'b1, 1'b0};
`ifdef MEM_STORE_MISALIGN_TRAP_EN
        tv[8] = '{32'h0000_2023, 32'h0000_0006, 32'h8888_8888, 0, 4'b0000, 32'h0, 1'b0, 1'b1};
        tv[9] = '{32'h0000_1023, 32'h0000_0005, 32'h9999_9999, 0, 4'b0000, 32'h0, 1'b0, 1'b1};
`else
        tv[8] = '{32'h0000_2023, 32'h0000_0006, 32'h8888_8888, 1, 4'b1111, 32'h0000_0004, 1'b1, 1'b0};
        tv[9] = '{32'h0000_1023, 32'h0000_0005, 32'h9999_9999, 0, 4'b0011, 32'h0000_0004, 1'b1, 1'b0};
`endif

        // reset state
        #2;
        chk1("rst req", req, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst done", done, 1'b0);
        chk1("rst err", err, 1'b0);
        chk32("rst addr", maddr, 32'h0);
        chk32("rst wdata", mwdata, 32'h0);
        chk32("rst wrbits", 32'(wrb), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) run_vec(i, tv[i]);

        // timeout on the TIMEOUT=4 instance
        ir = 32'h0000_2023; addr = 32'h0000_0010; wdata = 32'hCAFE_F00D; start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk1($sformatf("to req c%0d", k), b_req, 1'b1);
            chk1($sformatf("to err c%0d", k), b_err, 1'b0);
            step();
        end
        chk1("to done", b_done, 1'b1);
        chk1("to err", b_err, 1'b1);
        chk1("to req fin", b_req, 1'b0);
        chk1("to busy fin", b_busy, 1'b0);
        chk32("to wrbits fin", 32'(b_wrb), 32'h0);
        step();
        chk1("to done drop", b_done, 1'b0);
        chk1("to err drop", b_err, 1'b0);

        // ack coincident with the timeout cycle: ack wins
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk1($sformatf("tie req c%0d", k), b_req, 1'b1);
            ack = (k == 3);
            step();
        end
        ack = 1'b0;
        chk1("tie done", b_done, 1'b1);
        chk1("tie err", b_err, 1'b0);
        step();

        // async reset in the third wait cycle
        ir = 32'h0000_0023; addr = 32'h0000_3004; wdata = 32'h0BAD_0BAD; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk1("mid req before rst", req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("mid rst req", req, 1'b0);
        chk1("mid rst busy", busy, 1'b0);
        chk32("mid rst wrbits", 32'(wrb), 32'h0);
        chk32("mid rst addr", maddr, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk1("post rst idle req", req, 1'b0);

        // fresh SB, with a second start during REQ that must be ignored
        ir = 32'h0000_0023; addr = 32'h0000_0041; wdata = 32'h5A5A_5A5A; start = 1'b1;
        step();
        start = 1'b0;
        chk1("sb2 req", req, 1'b1);
        chk32("sb2 wrbits", 32'(wrb), 32'h2);
        ir = 32'h0000_2023; addr = 32'h0000_0080; wdata = 32'h0; start = 1'b1;
        step();
        start = 1'b0;
        chk1("sb2 req hold", req, 1'b1);
        chk32("sb2 addr hold", maddr, 32'h0000_0040);
        chk32("sb2 wrbits hold", 32'(wrb), 32'h2);
        chk32("sb2 wdata hold", mwdata, 32'h5A5A_5A5A);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk1("sb2 done", done, 1'b1);
        chk1("sb2 req fin", req, 1'b0);
        step();
        chk1("sb2 done drop", done, 1'b0);
        step();
        chk1("sb2 no queued req", req, 1'b0);
        chk1("sb2 no queued done", done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
